// File: rtl/video_timing_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_decoder_if
//  Description : Bundle of the raw sync/pixel input stream and the qualified,
//                coordinate-tagged output stream of video_timing_decoder.
//                master : video source side (drives sync/pixel inputs,
//                         observes decoded outputs)
//                slave  : decoder side
//  Signals     : vsync, hsync, data_enable, pix_in      source -> decoder
//                pix_out, pix_valid, pix_x, pix_y,      decoder -> sink
//                sof, eol, eof, meas_width, meas_height,
//                err_width, err_overflow, err_sync
//  Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_decoder_if #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int MAX_W = 1920,
  parameter int MAX_H = 1080,
  parameter int XW    = $clog2(MAX_W + 1),
  parameter int YW    = $clog2(MAX_H + 1)
);
  logic               vsync;
  logic               hsync;
  logic               data_enable;
  logic [CH*DW-1:0]   pix_in;

  logic [CH*DW-1:0]   pix_out;
  logic               pix_valid;
  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic               sof;
  logic               eol;
  logic               eof;
  logic [XW-1:0]      meas_width;
  logic [YW-1:0]      meas_height;
  logic               err_width;
  logic               err_overflow;
  logic               err_sync;

  modport master (
    output vsync, hsync, data_enable, pix_in,
    input  pix_out, pix_valid, pix_x, pix_y, sof, eol, eof,
           meas_width, meas_height, err_width, err_overflow, err_sync
  );

  modport slave (
    input  vsync, hsync, data_enable, pix_in,
    output pix_out, pix_valid, pix_x, pix_y, sof, eol, eof,
           meas_width, meas_height, err_width, err_overflow, err_sync
  );
endinterface
`default_nettype wire

// File: rtl/video_timing_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_decoder
//  Description : Front-end of the downscaler. Turns a raw vsync/hsync/
//                data_enable stream of CH x DW-bit pixels into a qualified
//                pixel stream with x/y coordinates and sof/eol/eof markers,
//                measures the active frame size and flags timing faults.
//  Ports       : clk    - single rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - video_timing_decoder_if.slave (raw input stream,
//                         decoded output stream, measurements, error flags)
//  Pipeline    : edge k   : raw inputs captured (stage 1)
//                edge k+1 : decoded pixel / counters / flags (stage 2)
//                edge k+2 : output registers (eol needs the stage-1 lookahead)
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_decoder #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int MAX_W = 1920,
  parameter int MAX_H = 1080,
  parameter int XW    = $clog2(MAX_W + 1),
  parameter int YW    = $clog2(MAX_H + 1)
) (
  input wire                    clk,
  input wire                    rst_n,
  video_timing_decoder_if.slave bus
);

  localparam int            C_PW    = CH * DW;
  localparam logic [XW-1:0] C_MAX_X = XW'(MAX_W);
  localparam logic [YW-1:0] C_MAX_Y = YW'(MAX_H);
  localparam logic [XW-1:0] C_X_ONE = XW'(1);
  localparam logic [YW-1:0] C_Y_ONE = YW'(1);

  typedef enum logic [0:0] {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Stage 1: raw input capture
  logic              r_s1_vs;
  logic              r_s1_hs;
  logic              r_s1_de;
  logic [C_PW-1:0]   r_s1_pix;
  logic              r_vs_prev;   // stage-1 vsync of the previous cycle

  // Frame bookkeeping
  logic [XW-1:0]     r_x;         // next column, saturates at MAX_W
  logic [YW-1:0]     r_y;         // completed lines, saturates at MAX_H
  logic              r_line0;     // still in the first line of the frame
  logic [XW-1:0]     r_width;     // width of line 0 of the current frame
  logic              r_in_line;   // a data_enable run is in progress
  logic              r_frame_pix; // current frame has accepted a pixel
  logic              r_err_w;
  logic              r_err_o;
  logic              r_err_s;
  logic [XW-1:0]     r_meas_w;
  logic [YW-1:0]     r_meas_h;

  // Stage 2: decoded pixel
  logic              r_s2_valid;
  logic [C_PW-1:0]   r_s2_pix;
  logic [XW-1:0]     r_s2_x;
  logic [YW-1:0]     r_s2_y;
  logic              r_s2_sof;
  logic              r_s2_eof;

  // Decode of the stage-1 sample
  logic              w_vs_rise;
  logic              w_live;
  logic              w_de_live;
  logic [XW-1:0]     w_px;
  logic [YW-1:0]     w_py;
  logic              w_in_range;
  logic              w_accept;
  logic              w_ovf;
  logic              w_sync_err;
  logic              w_line_end;
  logic              w_eof;
  logic [XW-1:0]     w_x_inc;
  logic [YW-1:0]     w_y_inc;
  logic [XW-1:0]     w_fin_w;
  logic [YW-1:0]     w_fin_h;

  // --------------------------------------------------------------------------
  // Input capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vs   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_pix  <= '0;
      r_vs_prev <= 1'b0;
    end else begin
      r_s1_vs   <= bus.vsync;
      r_s1_hs   <= bus.hsync;
      r_s1_de   <= bus.data_enable;
      r_s1_pix  <= bus.pix_in;
      r_vs_prev <= r_s1_vs;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_VS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-sample decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_vs_rise   = r_s1_vs & ~r_vs_prev;
    // The vsync-rise cycle already belongs to the new frame, even when
    // leaving WAIT_VS, so a coincident pixel becomes (0,0).
    w_live      = (r_state == ACTIVE) | w_vs_rise;
    w_de_live   = r_s1_de & w_live;
    w_px        = w_vs_rise ? '0 : r_x;
    w_py        = w_vs_rise ? '0 : r_y;
    w_in_range  = (w_px < C_MAX_X) && (w_py < C_MAX_Y);
    w_accept    = w_de_live & w_in_range;
    w_ovf       = w_de_live & ~w_in_range;
    w_sync_err  = w_de_live & (r_s1_hs | w_vs_rise);
    // A line closes on the data_enable fall or when vsync truncates it.
    w_line_end  = (r_state == ACTIVE) & r_in_line & (~r_s1_de | w_vs_rise);
    w_eof       = (r_state == ACTIVE) & w_vs_rise & r_frame_pix;
    w_x_inc     = (r_x == C_MAX_X) ? r_x : r_x + C_X_ONE;
    w_y_inc     = (r_y == C_MAX_Y) ? r_y : r_y + C_Y_ONE;
    // Closing-frame measurements: a line cut by vsync still counts, and if
    // it was line 0 its partial length is the frame width.
    w_fin_h     = r_in_line ? w_y_inc : r_y;
    w_fin_w     = r_line0 ? (r_in_line ? r_x : '0) : r_width;
    if (w_vs_rise) begin
      w_state_nxt = ACTIVE;
    end
  end

  // --------------------------------------------------------------------------
  // Frame counters, measurements and sticky errors
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line0     <= 1'b0;
      r_width     <= '0;
      r_in_line   <= 1'b0;
      r_frame_pix <= 1'b0;
      r_err_w     <= 1'b0;
      r_err_o     <= 1'b0;
      r_err_s     <= 1'b0;
      r_meas_w    <= '0;
      r_meas_h    <= '0;
    end else if (w_vs_rise) begin
      // New frame; errors restart with whatever this very cycle raises.
      r_x         <= w_de_live ? C_X_ONE : '0;
      r_y         <= '0;
      r_line0     <= 1'b1;
      r_width     <= '0;
      r_in_line   <= w_de_live;
      r_frame_pix <= w_accept;
      r_err_w     <= 1'b0;
      r_err_o     <= w_ovf;
      r_err_s     <= w_sync_err;
      if (w_eof) begin
        r_meas_w <= w_fin_w;
        r_meas_h <= w_fin_h;
      end
    end else if (r_state == ACTIVE) begin
      if (w_line_end) begin
        r_x       <= '0;
        r_y       <= w_y_inc;
        r_in_line <= 1'b0;
        r_line0   <= 1'b0;
        if (r_line0) begin
          r_width <= r_x;
        end else if (r_x != r_width) begin
          r_err_w <= 1'b1;
        end
      end else if (w_de_live) begin
        r_x       <= w_x_inc;
        r_in_line <= 1'b1;
      end
      if (w_accept) begin
        r_frame_pix <= 1'b1;
      end
      if (w_ovf) begin
        r_err_o <= 1'b1;
      end
      if (w_sync_err) begin
        r_err_s <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid       <= 1'b0;
      r_s2_pix         <= '0;
      r_s2_x           <= '0;
      r_s2_y           <= '0;
      r_s2_sof         <= 1'b0;
      r_s2_eof         <= 1'b0;
      bus.pix_valid    <= 1'b0;
      bus.pix_out      <= '0;
      bus.pix_x        <= '0;
      bus.pix_y        <= '0;
      bus.sof          <= 1'b0;
      bus.eol          <= 1'b0;
      bus.eof          <= 1'b0;
      bus.meas_width   <= '0;
      bus.meas_height  <= '0;
      bus.err_width    <= 1'b0;
      bus.err_overflow <= 1'b0;
      bus.err_sync     <= 1'b0;
    end else begin
      r_s2_valid       <= w_accept;
      r_s2_pix         <= r_s1_pix;
      r_s2_x           <= w_px;
      r_s2_y           <= w_py;
      r_s2_sof         <= w_accept & (w_px == '0) & (w_py == '0);
      r_s2_eof         <= w_eof;
      bus.pix_valid    <= r_s2_valid;
      bus.pix_out      <= r_s2_pix;
      bus.pix_x        <= r_s2_x;
      bus.pix_y        <= r_s2_y;
      bus.sof          <= r_s2_sof;
      // The stage-2 pixel ends its line unless the sample now in stage 1
      // is an accepted pixel of the same line (overflow drops also end it).
      bus.eol          <= r_s2_valid & ~(w_accept & ~w_vs_rise);
      bus.eof          <= r_s2_eof;
      bus.meas_width   <= r_meas_w;
      bus.meas_height  <= r_meas_h;
      bus.err_width    <= r_err_w;
      bus.err_overflow <= r_err_o;
      bus.err_sync     <= r_err_s;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_decoder
//  Description : Randomised frame stimulus with a frame-level reference model
//                feeding expected pixel and end-of-frame records into queues;
//                an independent monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_decoder;
  localparam int CH    = 4;
  localparam int DW    = 10;
  localparam int MAX_W = 8;
  localparam int MAX_H = 6;
  localparam int XW    = $clog2(MAX_W + 1);
  localparam int YW    = $clog2(MAX_H + 1);
  localparam int PW    = CH * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  video_timing_decoder_if #(.CH(CH), .DW(DW), .MAX_W(MAX_W), .MAX_H(MAX_H)) bus ();

  video_timing_decoder #(.CH(CH), .DW(DW), .MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [PW-1:0] pix;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          ew;
    logic          eo;
    logic          es;
  } pix_t;

  typedef struct packed {
    logic [XW-1:0] w;
    logic [YW-1:0] h;
    logic          ew;
    logic          eo;
    logic          es;
  } eof_t;

  pix_t q_pix[$];
  eof_t q_eof[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: frame/line bookkeeping with unbounded integers
  // --------------------------------------------------------------------------
  bit   m_active, m_prev_vs, m_prev_de, m_line0, m_has_pend;
  int   m_x, m_y, m_w0, m_frame_pix;
  bit   e_w, e_o, e_s;
  pix_t m_pend;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev_vs = 0; m_prev_de = 0; m_line0 = 0; m_has_pend = 0;
    m_x = 0; m_y = 0; m_w0 = 0; m_frame_pix = 0;
    e_w = 0; e_o = 0; e_s = 0;
  endtask

  task automatic model_step(input bit vs, input bit hs, input bit de, input logic [PW-1:0] p);
    bit   rise, acc, do_eof;
    eof_t er;
    pix_t pr;
    rise   = vs && !m_prev_vs;
    acc    = 0;
    do_eof = 0;
    er     = '0;
    pr     = '0;
    if (rise) begin
      if (m_active && m_frame_pix > 0) begin
        do_eof = 1;
        er.h = YW'(imin(m_y + (m_prev_de ? 1 : 0), MAX_H));
        er.w = XW'(m_line0 ? (m_prev_de ? imin(m_x, MAX_W) : 0) : m_w0);
      end
      m_active = 1; m_x = 0; m_y = 0; m_line0 = 1; m_w0 = 0; m_frame_pix = 0;
      e_w = 0; e_o = 0; e_s = 0;
    end else if (m_active && m_prev_de && !de) begin
      if (m_line0) begin
        m_w0 = imin(m_x, MAX_W);
        m_line0 = 0;
      end else if (imin(m_x, MAX_W) != m_w0) begin
        e_w = 1;
      end
      m_y++;
      m_x = 0;
    end
    if (m_active && de) begin
      if (hs || rise) e_s = 1;
      if (m_x < MAX_W && m_y < MAX_H) begin
        acc = 1;
        pr.pix = p;
        pr.x = XW'(m_x);
        pr.y = YW'(m_y);
        pr.sof = (m_x == 0 && m_y == 0);
        m_frame_pix++;
      end else begin
        e_o = 1;
      end
      m_x++;
    end
    // eol of the previous pixel is known only once this cycle is seen
    if (m_has_pend) begin
      m_pend.eol = !(acc && !rise);
      q_pix.push_back(m_pend);
      m_has_pend = 0;
    end
    if (acc) begin
      pr.ew = e_w; pr.eo = e_o; pr.es = e_s;
      m_pend = pr;
      m_has_pend = 1;
    end
    if (do_eof) begin
      er.ew = e_w; er.eo = e_o; er.es = e_s;
      q_eof.push_back(er);
    end
    m_prev_vs = vs;
    m_prev_de = de;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drv(input bit vs, input bit hs, input bit de);
    logic [PW-1:0] p;
    @(posedge clk);
    #1;
    p = PW'({$urandom, $urandom});
    bus.vsync = vs; bus.hsync = hs; bus.data_enable = de; bus.pix_in = p;
    model_step(vs, hs, de, p);
  endtask

  task automatic vs_rise();
    drv(1, 0, 0);
    drv(1, 0, 0);
    repeat ($urandom_range(1, 3)) drv(0, 0, 0);
  endtask

  task automatic line(input int w, input int gap, input bit bad_hs);
    for (int i = 0; i < w; i++) drv(0, bad_hs && (i == w / 2), 1);
    for (int g = 0; g < gap; g++) drv(0, g == 0, 0);
  endtask

  // line of w pixels with a vsync rise at pixel k (starts a new frame)
  task automatic line_vs(input int w, input int k);
    for (int i = 0; i < w; i++) drv((i == k) || (i == k + 1), 0, 1);
    drv(0, 1, 0);
    drv(0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    chk(name, 256'({bus.pix_out, bus.pix_valid, bus.pix_x, bus.pix_y, bus.sof, bus.eol,
                    bus.eof, bus.meas_width, bus.meas_height, bus.err_width,
                    bus.err_overflow, bus.err_sync}), 256'(0));
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin : monitor
    pix_t gp, xp;
    eof_t ge, xe;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.pix_valid) begin
          gp = {bus.pix_out, bus.pix_x, bus.pix_y, bus.sof, bus.eol,
                bus.err_width, bus.err_overflow, bus.err_sync};
          if (q_pix.size() == 0) begin
            chk("pix_unexpected", 256'(gp), 256'(0));
          end else begin
            xp = q_pix.pop_front();
            chk("pixel", 256'(gp), 256'(xp));
          end
        end
        if (bus.eof) begin
          ge = {bus.meas_width, bus.meas_height, bus.err_width, bus.err_overflow, bus.err_sync};
          if (q_eof.size() == 0) begin
            chk("eof_unexpected", 256'(ge), 256'(0));
          end else begin
            xe = q_eof.pop_front();
            chk("eof_meas", 256'(ge), 256'(xe));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    bus.vsync = 0; bus.hsync = 0; bus.data_enable = 0; bus.pix_in = '0;
    model_reset();
    #2 rst_n = 0;
    #1 check_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check_zero("reset_state");

    // data_enable before the first vsync is ignored
    line(4, 2, 0);
    line(4, 2, 1);
    vs_rise();                                   // first vsync: no eof

    for (int l = 0; l < 4; l++) line(6, 2, 0);   // 4 x 6 baseline
    vs_rise();
    line(6, 2, 0); line(6, 2, 0); line(5, 2, 0); line(6, 2, 0);  // width error
    vs_rise();
    line(6, 1, 0); line(10, 1, 0); line(6, 1, 0);               // x overflow
    vs_rise();
    for (int l = 0; l < 7; l++) line(3, 1, 0);                  // y overflow
    vs_rise();
    line(6, 2, 0); line(6, 2, 0); line_vs(6, 3);                // vsync mid-line
    line(6, 2, 0); line(6, 2, 1);                               // hsync during DE
    vs_rise();

    for (int f = 0; f < 30; f++) begin
      int nl, w0, w;
      nl = $urandom_range(1, 7);
      w0 = $urandom_range(1, MAX_W);
      for (int l = 0; l < nl; l++) begin
        w = ($urandom_range(0, 4) == 0) ? $urandom_range(1, MAX_W + 2) : w0;
        line(w, $urandom_range(1, 3), $urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 3) == 0) line_vs($urandom_range(2, 6), $urandom_range(0, 1));
      else vs_rise();
    end

    // reset in the middle of line 3
    line(6, 2, 0); line(6, 2, 0);
    drv(0, 0, 1); drv(0, 0, 1); drv(0, 0, 1);
    #2 rst_n = 0;
    bus.vsync = 0; bus.hsync = 0; bus.data_enable = 0;
    #1 check_zero("reset_midframe");
    q_pix.delete();
    q_eof.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    line(5, 2, 0); line(5, 2, 0);                // ignored: no vsync yet
    vs_rise();                                   // no eof for aborted frame
    for (int l = 0; l < 3; l++) line(4, 2, 0);
    vs_rise();
    for (int l = 0; l < 4; l++) line(6, 2, 0);
    vs_rise();
    repeat (6) drv(0, 0, 0);

    chk("pix_queue_drained", 256'(q_pix.size()), 256'(0));
    chk("eof_queue_drained", 256'(q_eof.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/video_timing_decoder.md
# video_timing_decoder

Parametrised input front-end for the anti-aliasing downscaler. Decodes a raw vsync/hsync/data_enable pixel stream carrying CH channels of DW bits into a qualified pixel stream tagged with x/y coordinates and start/end markers. Also measures active frame width/height and flags timing faults. Sits between the video source and the FIR scaler core, replacing per-design ad-hoc sync handling; generalised from fixed 3×8-bit RGB to arbitrary channel count and width.

## Interface
Parameters:
- CH, 3, number of colour channels
- DW, 8, bits per channel
- MAX_W, 1920, maximum active pixels per line
- MAX_H, 1080, maximum active lines per frame
- XW, $clog2(MAX_W+1), derived; coordinate/count width for x
- YW, $clog2(MAX_H+1), derived; coordinate/count width for y

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vsync  in  1  frame sync, active high; a rising edge starts a frame
- hsync  in  1  line sync, active high; used only for fault checking
- data_enable  in  1  active-pixel qualifier
- pix_in  in  CH*DW  channel 0 in LSBs
- pix_out  out  CH*DW  pix_in delayed
- pix_valid  out  1  pix_out/pix_x/pix_y valid
- pix_x  out  XW  column of pix_out, 0-based
- pix_y  out  YW  row of pix_out, 0-based
- sof  out  1  with first pixel of frame (x=0,y=0)
- eol  out  1  with last pixel of each line
- eof  out  1  one-cycle frame-complete pulse
- meas_width  out  XW  pixel count of first line of last completed frame
- meas_height  out  YW  line count of last completed frame
- err_width  out  1  sticky: a line width differed from line 0
- err_overflow  out  1  sticky: x or y exceeded MAX_W/MAX_H
- err_sync  out  1  sticky: data_enable high while hsync high, or vsync rise during data_enable

## Operation
- States: WAIT_VS (post-reset), ACTIVE. WAIT_VS ignores data_enable; pix_valid=0. First vsync rising edge (vsync & !vsync_q) → ACTIVE. No other transition except reset.
- vsync rise in ACTIVE: x←0, y←0, line0 flag set, err_* cleared; previous frame closes (see eof). vsync level otherwise ignored.
- data_enable high: pixel accepted at (x,y); x++. Falling edge of data_enable ends line: y++, x←0; if line0, latch width as frame width; else compare, mismatch → err_width.
- Pixel with x ≥ MAX_W or y ≥ MAX_H: dropped (no pix_valid), counters saturate, err_overflow set.
- eol: asserted on a pixel whose following input cycle has data_enable low or a vsync rise.
- eof: pulses one cycle on a vsync rise when the closing frame had ≥1 accepted pixel; same cycle meas_width/meas_height update (meas_height counts completed lines, incl. a line truncated by the vsync rise). No eof for the first vsync after reset.
- vsync rise coincident with data_enable high: that pixel is (0,0) of the new frame with sof; err_sync set in the new frame.
- err_* sticky within a frame, cleared on the vsync rise (errors of that rise cycle itself are kept).

## Timing
- Two-stage pipeline: input sampled at edge k appears on pix_out/pix_valid/pix_x/pix_y/sof/eol after edge k+2; fixed, no back-pressure.
- eof and meas_* update aligned with the output cycle of the vsync-rise input cycle (latency 2), i.e. with the new frame's sof if that pixel is valid.
- err_* set with latency 2 from the offending input cycle.
- Async reset: all outputs 0 immediately, state WAIT_VS, counters/measurements 0; pipeline contents discarded. Reset mid-frame: no eof emitted for the aborted frame.
- Throughput: one pixel per clock, back-to-back lines with a single blanking cycle supported.

## Test plan
- Reset, vsync rise, 4 lines × 6 pixels (DE gaps 2 cycles), vsync rise → 24 pix_valid, x 0..5, y 0..3, sof on first, eol on each x=5, eof with meas_width=6, meas_height=4, no errors; first vsync gives no eof.
- CH=4, DW=10, pixel value = counter → pix_out equals pix_in exactly 2 cycles later, channel order preserved.
- Line 2 has 5 pixels instead of 6 → err_width=1 from that line's end until next vsync rise, then 0.
- MAX_W=8, line of 10 pixels → 8 valid pixels (x 0..7), eol on x=7, err_overflow=1.
- vsync rise while DE high mid-line → previous pixel gets eol, eof pulse, new pixel (0,0) with sof, err_sync=1.
- rst_n low during frame line 3 → outputs 0 asynchronously; after release DE ignored until vsync rise; next frame measures normally.
